// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the single SRAM data port shared by the scalar and vector LSUs.
// Port 1 may lock the port for a vector burst; the lock is force-released after MAX_LOCK cycles.
//
// state    | meaning
// UNLOCKED | normal round-robin; p1 may acquire the lock
// LOCKED   | p1 owns the port while p1_lock holds; p0 stalled
// BLOCKED  | lock force-released; round-robin, p1 may not relock until p0 is served or idle
module dmem_arbiter #(
  parameter int MAX_LOCK = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wmask,
  input  logic        p0_write,
  output logic [31:0] p0_rdata,
  output logic        p0_resp_valid,

  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wmask,
  input  logic        p1_write,
  output logic [31:0] p1_rdata,
  output logic        p1_resp_valid,
  input  logic        p1_lock,

  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wmask,
  output logic        m_write,
  input  logic [31:0] m_rdata,
  input  logic        m_resp_valid
);

  typedef enum logic [1:0] {UNLOCKED, LOCKED, BLOCKED} lock_state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

  lock_state_t      state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             rd_pending_q, rd_pending_d;
  logic             rd_owner_q, rd_owner_d;

  logic lock_hold;
  logic grant0, grant1;
  logic hs0, hs1;

  // Lock only takes effect while p1_lock is still asserted, so dropping it frees p0 the same cycle.
  always_comb begin
    lock_hold = (state_q == LOCKED) && p1_lock;
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (lock_hold) begin
      grant1 = 1'b1;
    end else if (p0_valid && p1_valid) begin
      grant0 = last_grant_q;
      grant1 = !last_grant_q;
    end else begin
      grant0 = p0_valid;
      grant1 = p1_valid;
    end
  end

  assign p0_ready = grant0 && p0_valid && !reset;
  assign p1_ready = grant1 && p1_valid && !reset;
  assign hs0      = p0_ready;
  assign hs1      = p1_ready;

  assign m_valid = hs0 || hs1;
  assign m_addr  = grant1 ? p1_addr  : p0_addr;
  assign m_wdata = grant1 ? p1_wdata : p0_wdata;
  assign m_wmask = grant1 ? p1_wmask : p0_wmask;
  assign m_write = grant1 ? p1_write : p0_write;

  assign p0_rdata      = m_rdata;
  assign p1_rdata      = m_rdata;
  assign p0_resp_valid = m_resp_valid && rd_pending_q && !rd_owner_q && !reset;
  assign p1_resp_valid = m_resp_valid && rd_pending_q &&  rd_owner_q && !reset;

  always_comb begin
    rd_pending_d = 1'b0;
    rd_owner_d   = rd_owner_q;
    if (hs0 && !p0_write) begin
      rd_pending_d = 1'b1;
      rd_owner_d   = 1'b0;
    end else if (hs1 && !p1_write) begin
      rd_pending_d = 1'b1;
      rd_owner_d   = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    last_grant_d = last_grant_q;
    if (hs0) begin
      last_grant_d = 1'b0;
    end else if (hs1) begin
      last_grant_d = 1'b1;
    end
    case (state_q)
      UNLOCKED: begin
        if (hs1 && p1_lock) begin
          state_d    = LOCKED;
          lock_cnt_d = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (!p1_lock) begin
          state_d    = UNLOCKED;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == MAX_CNT) begin
          state_d      = BLOCKED;
          lock_cnt_d   = '0;
          last_grant_d = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
      BLOCKED: begin
        if (hs0 || !p0_valid) begin
          state_d = UNLOCKED;
        end
      end
      default: begin
        state_d    = UNLOCKED;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= UNLOCKED;
      lock_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      last_grant_q <= last_grant_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 1-cycle-latency SRAM model.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 unit later.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_valid, p0_ready, p0_write, p0_resp_valid;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [3:0]  p0_wmask;
  logic        p1_valid, p1_ready, p1_write, p1_resp_valid, p1_lock;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [3:0]  p1_wmask;
  logic        m_valid, m_write;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wmask;
  logic [31:0] m_rdata = 32'h0;
  logic        m_resp_valid = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_arbiter #(.MAX_LOCK(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wmask(p0_wmask), .p0_write(p0_write), .p0_rdata(p0_rdata), .p0_resp_valid(p0_resp_valid),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wmask(p1_wmask), .p1_write(p1_write), .p1_rdata(p1_rdata), .p1_resp_valid(p1_resp_valid),
    .p1_lock(p1_lock),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask), .m_write(m_write),
    .m_rdata(m_rdata), .m_resp_valid(m_resp_valid)
  );

  always #5 clk = ~clk;

  // SRAM model: word at index i initialised to {16'hC0DE, i}
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};

  always @(posedge clk) begin
    logic [31:0] w;
    m_resp_valid <= m_valid && !m_write;
    if (m_valid && !m_write) m_rdata <= mem[m_addr[11:2]];
    if (m_valid && m_write) begin
      w = mem[m_addr[11:2]];
      for (int b = 0; b < 4; b++) if (m_wmask[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
      mem[m_addr[11:2]] <= w;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drv0(input logic v, input logic [31:0] a, input logic wr,
                      input logic [31:0] wd, input logic [3:0] wm);
    p0_valid = v; p0_addr = a; p0_write = wr; p0_wdata = wd; p0_wmask = wm;
  endtask

  task automatic drv1(input logic v, input logic [31:0] a, input logic wr,
                      input logic [31:0] wd, input logic [3:0] wm, input logic lk);
    p1_valid = v; p1_addr = a; p1_write = wr; p1_wdata = wd; p1_wmask = wm; p1_lock = lk;
  endtask

  initial begin
    reset = 1'b1;
    drv0(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drv1(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);

    // held in reset: nothing granted
    tick(); drv0(1'b1, 32'h100, 1'b0, 32'h0, 4'h0); #1;
    chk1("rst_p0_ready", p0_ready, 1'b0);
    chk1("rst_m_valid", m_valid, 1'b0);

    // single p0 read
    tick(); reset = 1'b0; #1;
    chk1("rd0_p0_ready", p0_ready, 1'b1);
    chk1("rd0_m_valid", m_valid, 1'b1);
    chk32("rd0_m_addr", m_addr, 32'h100);
    tick(); drv0(1'b0, 32'h0, 1'b0, 32'h0, 4'h0); #1;
    chk1("rd0_p0_resp", p0_resp_valid, 1'b1);
    chk32("rd0_p0_rdata", p0_rdata, 32'hC0DE0040);
    chk1("rd0_p1_resp", p1_resp_valid, 1'b0);

    // both valid: p0 was last, so p1,p0,p1,p0
    tick();
    drv0(1'b1, 32'h104, 1'b0, 32'h0, 4'h0);
    drv1(1'b1, 32'h108, 1'b0, 32'h0, 4'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      #1;
      chk1("alt_p1_ready", p1_ready, (k % 2) == 0);
      chk1("alt_p0_ready", p0_ready, (k % 2) == 1);
      chk1("alt_p1_resp", p1_resp_valid, (k % 2) == 1);
      chk1("alt_p0_resp", p0_resp_valid, k == 2);
      if ((k % 2) == 1) chk32("alt_p1_rdata", p1_rdata, 32'hC0DE0042);
      if (k == 2) chk32("alt_p0_rdata", p0_rdata, 32'hC0DE0041);
    end
    tick();
    drv0(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drv1(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    chk1("alt_last_p0_resp", p0_resp_valid, 1'b1);
    chk1("alt_last_p1_resp", p1_resp_valid, 1'b0);
    chk32("alt_last_p0_rdata", p0_rdata, 32'hC0DE0041);

    // p1 masked write then p0 readback
    tick(); drv1(1'b1, 32'h200, 1'b1, 32'hDEADBEEF, 4'b0011, 1'b0); #1;
    chk1("wr_p1_ready", p1_ready, 1'b1);
    chk1("wr_m_write", m_write, 1'b1);
    chk32("wr_m_addr", m_addr, 32'h200);
    chk32("wr_m_wdata", m_wdata, 32'hDEADBEEF);
    chk32("wr_m_wmask", {28'h0, m_wmask}, 32'h3);
    tick();
    drv1(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
    drv0(1'b1, 32'h200, 1'b0, 32'h0, 4'h0);
    #1;
    chk1("wb_p0_ready", p0_ready, 1'b1);
    chk1("wb_p1_resp", p1_resp_valid, 1'b0);
    tick(); drv0(1'b0, 32'h0, 1'b0, 32'h0, 4'h0); #1;
    chk1("wb_p0_resp", p0_resp_valid, 1'b1);
    chk32("wb_p0_rdata", p0_rdata, 32'hC0DEBEEF);

    // lock: p1 wins tie, then holds for 16 locked cycles
    tick();
    drv0(1'b1, 32'h104, 1'b0, 32'h0, 4'h0);
    drv1(1'b1, 32'h108, 1'b0, 32'h0, 4'h0, 1'b1);
    #1;
    chk1("lk_p1_ready", p1_ready, 1'b1);
    chk1("lk_p0_ready", p0_ready, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick(); #1;
      chk1("lk_p0_stall", p0_ready, 1'b0);
      chk1("lk_p1_ready_hold", p1_ready, 1'b1);
    end
    tick(); #1;
    chk1("frel_p0_ready", p0_ready, 1'b1);
    chk1("frel_p1_ready", p1_ready, 1'b0);
    tick(); #1;
    chk1("relock_p1_ready", p1_ready, 1'b1);
    chk1("relock_p0_ready", p0_ready, 1'b0);

    // gaps while locked keep p0 stalled; dropping p1_lock frees p0 the same cycle
    tick(); drv1(1'b0, 32'h108, 1'b0, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      chk1("gap_p0_ready", p0_ready, 1'b0);
      chk1("gap_m_valid", m_valid, 1'b0);
    end
    tick(); drv1(1'b1, 32'h108, 1'b0, 32'h0, 4'h0, 1'b0); #1;
    chk1("unl_p0_ready", p0_ready, 1'b1);
    chk1("unl_p1_ready", p1_ready, 1'b0);

    // p1 read, then reset while its response is on the bus
    tick();
    drv0(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drv1(1'b1, 32'h10C, 1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    chk1("rr_p1_ready", p1_ready, 1'b1);
    chk1("rr_p0_resp", p0_resp_valid, 1'b1);
    chk32("rr_p0_rdata", p0_rdata, 32'hC0DE0041);
    tick();
    reset = 1'b1;
    drv0(1'b1, 32'h100, 1'b0, 32'h0, 4'h0);
    drv1(1'b1, 32'h108, 1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    chk1("rr_p1_resp_sup", p1_resp_valid, 1'b0);
    chk1("rr_rst_p0_ready", p0_ready, 1'b0);
    chk1("rr_rst_p1_ready", p1_ready, 1'b0);
    chk1("rr_rst_m_valid", m_valid, 1'b0);
    tick(); reset = 1'b0; #1;
    chk1("post_rst_p0_ready", p0_ready, 1'b1);
    chk1("post_rst_p1_ready", p1_ready, 1'b0);
    chk1("post_rst_p1_resp", p1_resp_valid, 1'b0);

    // reset mid-burst drops the lock
    tick(); p1_lock = 1'b1; #1;
    chk1("mb_p1_ready", p1_ready, 1'b1);
    tick(); #1;
    chk1("mb_p0_stall", p0_ready, 1'b0);
    tick(); reset = 1'b1; #1;
    chk1("mb_rst_m_valid", m_valid, 1'b0);
    tick(); reset = 1'b0; #1;
    chk1("mb_post_p0_ready", p0_ready, 1'b1);
    chk1("mb_post_p1_ready", p1_ready, 1'b0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
